// File: rtl/video_fetch_pkg.sv
// Shared types and constants for the video fetcher.
// The ULA+ palette path is selected with the VIDEO_ULAPLUS_EN macro in video_fetch.sv.
package video_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_BMP,
    REQ_ATTR,
    WAIT_ATTR,
    REQ_INK,
    REQ_PAPER,
    DONE
  } fetch_state_t;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_BMP,
    TAG_ATTR,
    TAG_INK,
    TAG_PAPER
  } fetch_tag_t;

  localparam logic [14:0] SCREEN_ATTR_BASE = 15'h1800;

endpackage

// File: rtl/video_fetch_addr.sv
// Combinational read address / palette index for the request a given fetch state issues.
module video_fetch_addr
  import video_fetch_pkg::*;
(
  input  fetch_state_t state,
  input  logic [7:0]   y,
  input  logic [4:0]   x,
  input  logic [7:0]   attr,
  output logic [14:0]  addr,
  output logic         is_up
);

  always_comb begin
    addr  = 15'h0000;
    is_up = 1'b0;
    case (state)
      REQ_BMP:   addr = {2'b00, y[7:6], y[2:0], y[5:3], x};
      REQ_ATTR:  addr = SCREEN_ATTR_BASE + {5'b00000, y[7:3], x};
      // Palette entries live in the 64-byte ULA+ space, selected by is_up.
      REQ_INK: begin
        addr  = {9'h000, attr[7:6], 1'b0, attr[2:0]};
        is_up = 1'b1;
      end
      REQ_PAPER: begin
        addr  = {9'h000, attr[7:6], 1'b1, attr[5:3]};
        is_up = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/video_fetch.sv
// Per-cell screen fetcher feeding the pixel shifter: bitmap + attribute reads, and ULA+ ink/paper
// palette reads when built with VIDEO_ULAPLUS_EN defined.
module video_fetch
  import video_fetch_pkg::*;
(
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        fetch_go,
  input  logic [7:0]  fetch_y,
  input  logic [4:0]  fetch_x,
  input  logic        ulaplus_active,
  output logic        video_read_req,
  output logic        video_read_req_is_up,
  output logic [14:0] video_read_addr,
  input  logic        video_read_req_ack,
  input  logic        video_data_valid,
  input  logic [7:0]  vd,
  input  logic        load,
  output logic [7:0]  out_bitmap,
  output logic [7:0]  out_attr,
  output logic [7:0]  out_ink,
  output logic [7:0]  out_paper,
  output logic        out_valid,
  output logic        busy,
  output logic        underrun,
  output logic        overrun
);

  // Handshake: req is held with addr/is_up frozen until a cycle with ack high; the data for
  // that request arrives with video_data_valid exactly one cycle later.
  fetch_state_t state, state_next;
  fetch_tag_t   tag, tag_next;
  logic [7:0]   y_q, y_eff, stg_bmp, stg_attr, attr_eff;
  logic [4:0]   x_q, x_eff;
  logic         ulaplus_q, staging_full, accept, complete, req_d;
  logic [14:0]  gen_addr;
  logic         gen_is_up;

  always_comb begin
    state_next = state;
    tag_next   = tag;
    accept     = 1'b0;
    complete   = 1'b0;
    if (video_data_valid) tag_next = TAG_NONE;
    case (state)
      IDLE: if (fetch_go && !staging_full) begin
        accept     = 1'b1;
        state_next = REQ_BMP;
      end
      REQ_BMP: if (video_read_req_ack) begin
        tag_next   = TAG_BMP;
        state_next = REQ_ATTR;
      end
      REQ_ATTR: if (video_read_req_ack) begin
        tag_next   = TAG_ATTR;
        state_next = ulaplus_q ? WAIT_ATTR : DONE;
      end
`ifdef VIDEO_ULAPLUS_EN
      // Palette indices depend on the attribute byte, so wait for it to return.
      WAIT_ATTR: if (video_data_valid && tag == TAG_ATTR) state_next = REQ_INK;
      REQ_INK: if (video_read_req_ack) begin
        tag_next   = TAG_INK;
        state_next = REQ_PAPER;
      end
      REQ_PAPER: if (video_read_req_ack) begin
        tag_next   = TAG_PAPER;
        state_next = DONE;
      end
`endif
      DONE: if (tag_next == TAG_NONE) begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign y_eff    = (state == IDLE) ? fetch_y : y_q;
  assign x_eff    = (state == IDLE) ? fetch_x : x_q;
  assign attr_eff = (video_data_valid && tag == TAG_ATTR) ? vd : stg_attr;
  assign req_d    = (state_next == REQ_BMP) || (state_next == REQ_ATTR) ||
                    (state_next == REQ_INK) || (state_next == REQ_PAPER);
  assign busy     = (state != IDLE);

  video_fetch_addr u_addr (
    .state (state_next),
    .y     (y_eff),
    .x     (x_eff),
    .attr  (attr_eff),
    .addr  (gen_addr),
    .is_up (gen_is_up)
  );

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      tag                  <= TAG_NONE;
      video_read_req       <= 1'b0;
      video_read_req_is_up <= 1'b0;
      video_read_addr      <= '0;
      y_q                  <= '0;
      x_q                  <= '0;
      stg_bmp              <= '0;
      stg_attr             <= '0;
      staging_full         <= 1'b0;
      out_bitmap           <= '0;
      out_attr             <= '0;
      out_valid            <= 1'b0;
      underrun             <= 1'b0;
      overrun              <= 1'b0;
    end else begin
      state          <= state_next;
      tag            <= tag_next;
      video_read_req <= req_d;
      if (req_d) begin
        video_read_addr      <= gen_addr;
        video_read_req_is_up <= gen_is_up;
      end
      if (accept) begin
        y_q <= fetch_y;
        x_q <= fetch_x;
      end
      if (video_data_valid && tag == TAG_BMP)  stg_bmp  <= vd;
      if (video_data_valid && tag == TAG_ATTR) stg_attr <= vd;
      // Completion beats a coincident load; that load reports underrun instead.
      if (complete) staging_full <= 1'b1;
      else if (load && staging_full) staging_full <= 1'b0;
      if (load) begin
        out_valid <= staging_full;
        if (staging_full) begin
          out_bitmap <= stg_bmp;
          out_attr   <= stg_attr;
        end
      end
      underrun <= load && !staging_full;
      overrun  <= fetch_go && !accept;
    end
  end

`ifdef VIDEO_ULAPLUS_EN
  logic [7:0] stg_ink, stg_paper;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ulaplus_q <= 1'b0;
      stg_ink   <= '0;
      stg_paper <= '0;
      out_ink   <= '0;
      out_paper <= '0;
    end else begin
      if (accept) begin
        ulaplus_q <= ulaplus_active;
        stg_ink   <= '0;
        stg_paper <= '0;
      end
      if (video_data_valid && tag == TAG_INK)   stg_ink   <= vd;
      if (video_data_valid && tag == TAG_PAPER) stg_paper <= vd;
      if (load && staging_full) begin
        out_ink   <= stg_ink;
        out_paper <= stg_paper;
      end
    end
  end
`else
  logic unused_ulaplus;
  assign unused_ulaplus = ulaplus_active;
  assign ulaplus_q      = 1'b0;
  assign out_ink        = '0;
  assign out_paper      = '0;
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: arbiter/RAM responder with a request scoreboard, and per-scenario tasks
// checking staged outputs against a screen-layout model.
module tb_video_fetch;

`ifdef VIDEO_ULAPLUS_EN
  localparam bit ULA_BUILD = 1'b1;
`else
  localparam bit ULA_BUILD = 1'b0;
`endif

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_go = 1'b0;
  logic [7:0]  fetch_y = '0;
  logic [4:0]  fetch_x = '0;
  logic        ulaplus_active = 1'b0;
  logic        video_read_req, video_read_req_is_up;
  logic [14:0] video_read_addr;
  logic        video_read_req_ack = 1'b0;
  logic        video_data_valid = 1'b0;
  logic [7:0]  vd = '0;
  logic        load = 1'b0;
  logic [7:0]  out_bitmap, out_attr, out_ink, out_paper;
  logic        out_valid, busy, underrun, overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0]  scr_mem [0:32767];
  logic [7:0]  pal_mem [0:63];
  logic [15:0] exp_q[$];
  logic [7:0]  exp_bitmap, exp_attr, exp_ink, exp_paper;

  always #18 clk28 = ~clk28;

  video_fetch dut (
    .clk28                (clk28),
    .rst_n                (rst_n),
    .fetch_go             (fetch_go),
    .fetch_y              (fetch_y),
    .fetch_x              (fetch_x),
    .ulaplus_active       (ulaplus_active),
    .video_read_req       (video_read_req),
    .video_read_req_is_up (video_read_req_is_up),
    .video_read_addr      (video_read_addr),
    .video_read_req_ack   (video_read_req_ack),
    .video_data_valid     (video_data_valid),
    .vd                   (vd),
    .load                 (load),
    .out_bitmap           (out_bitmap),
    .out_attr             (out_attr),
    .out_ink              (out_ink),
    .out_paper            (out_paper),
    .out_valid            (out_valid),
    .busy                 (busy),
    .underrun             (underrun),
    .overrun              (overrun)
  );

  // Screen layout model: thirds of 2 KB, pixel row within char, char row, column.
  function automatic logic [14:0] bmp_addr(input int y, input int x);
    return 15'((y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x);
  endfunction

  function automatic logic [14:0] attr_addr(input int y, input int x);
    return 15'(6144 + (y / 8) * 32 + x);
  endfunction

  function automatic logic [5:0] ink_idx(input int a);
    return 6'((a / 64) * 16 + a % 8);
  endfunction

  function automatic logic [5:0] paper_idx(input int a);
    return 6'((a / 64) * 16 + 8 + (a / 8) % 8);
  endfunction

  task automatic build_expected(input int y, input int x, input bit up);
    int a;
    exp_q.delete();
    a = int'(scr_mem[attr_addr(y, x)]);
    exp_q.push_back({1'b0, bmp_addr(y, x)});
    exp_q.push_back({1'b0, attr_addr(y, x)});
    exp_bitmap = scr_mem[bmp_addr(y, x)];
    exp_attr   = 8'(a);
    exp_ink    = 8'h00;
    exp_paper  = 8'h00;
    if (up && ULA_BUILD) begin
      exp_q.push_back({10'b1000000000, ink_idx(a)});
      exp_q.push_back({10'b1000000000, paper_idx(a)});
      exp_ink   = pal_mem[ink_idx(a)];
      exp_paper = pal_mem[paper_idx(a)];
    end
  endtask

  // Drives one fetch and acts as arbiter + RAM; acked requests are scored against exp_q.
  task automatic do_fetch(input logic [7:0] y, input logic [4:0] x, input logic up,
                          input int max_delay, input int first_delay, input bit stray,
                          input int load_at, input int go_at, output int cycles,
                          output int unstable, output int underruns, output int overruns);
    int delay;
    bit pend, seen;
    logic [7:0]  pend_data;
    logic [15:0] held, obs, e;
    fetch_y = y; fetch_x = x; ulaplus_active = up; fetch_go = 1'b1;
    @(negedge clk28);
    fetch_go = 1'b0;
    pend = 1'b0; seen = 1'b0; unstable = 0; underruns = 0; overruns = 0; cycles = 64;
    delay = (first_delay >= 0) ? first_delay : int'($urandom_range(0, max_delay));
    for (int c = 0; c < 64; c++) begin
      if (underrun) underruns++;
      if (overrun) overruns++;
      if (!busy && !pend) begin
        cycles = c;
        break;
      end
      video_read_req_ack = 1'b0;
      video_data_valid = 1'b0;
      load = (c == load_at);
      fetch_go = (c == go_at);
      if (c == go_at) begin
        fetch_y = ~y; fetch_x = ~x;
      end
      if (pend) begin
        video_data_valid = 1'b1; vd = pend_data; pend = 1'b0;
      end else if (stray && video_read_req && delay > 0) begin
        video_data_valid = 1'b1; vd = 8'($urandom);
      end
      if (video_read_req) begin
        obs = {video_read_req_is_up, video_read_addr};
        if (!seen) begin
          held = obs; seen = 1'b1;
        end else if (obs !== held) unstable++;
        if (delay == 0) begin
          video_read_req_ack = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL req_extra: got is_up/addr %h, expected no request", obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              errors++;
              $display("FAIL req_addr: got is_up/addr %h, expected %h", obs, e);
            end
          end
          pend = 1'b1;
          pend_data = video_read_req_is_up ? pal_mem[video_read_addr[5:0]] : scr_mem[video_read_addr];
          seen = 1'b0;
          delay = int'($urandom_range(0, max_delay));
        end else delay--;
      end
      @(negedge clk28);
    end
    video_read_req_ack = 1'b0; video_data_valid = 1'b0; load = 1'b0; fetch_go = 1'b0;
    fetch_y = y; fetch_x = x;
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk28);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk28);
    checks++;
    if ({video_read_req, video_read_req_is_up, video_read_addr, busy, underrun, overrun, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b up=%b addr=%h busy=%b ur=%b or=%b ov=%b, expected all 0",
               video_read_req, video_read_req_is_up, video_read_addr, busy, underrun, overrun, out_valid);
    end
    checks++;
    if ({out_bitmap, out_attr, out_ink, out_paper} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h%h%h%h, expected 00000000", out_bitmap, out_attr, out_ink, out_paper);
    end
    rst_n = 1'b1;
    @(negedge clk28);
    checks++;
    if (busy !== 1'b0 || video_read_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b req=%b, expected 0 0", busy, video_read_req);
    end
  endtask

  task automatic test_basic();
    int cyc, uns, ur, ov;
    scr_mem[15'h0000] = 8'hAA;
    scr_mem[15'h1800] = 8'h38;
    build_expected(0, 0, 1'b0);
    do_fetch(8'd0, 5'd0, 1'b0, 0, 0, 1'b0, -1, -1, cyc, uns, ur, ov);
    checks++;
    if (cyc > 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, %0d requests missing, expected <=8 and 0", cyc, exp_q.size());
    end
    do_load();
    checks++;
    if (out_bitmap !== 8'hAA || out_attr !== 8'h38) begin
      errors++;
      $display("FAIL basic_data: got bmp=%h attr=%h, expected AA 38", out_bitmap, out_attr);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: got %b, expected 1", out_valid);
    end
  endtask

  task automatic test_addr();
    int cyc, uns, ur, ov;
    build_expected(100, 17, 1'b0);
    do_fetch(8'd100, 5'd17, 1'b0, 0, 0, 1'b0, -1, -1, cyc, uns, ur, ov);
    checks++;
    if (cyc > 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL addr_done: got %0d cycles, %0d missing, expected <=8 and 0", cyc, exp_q.size());
    end
    do_load();
    checks++;
    if (out_bitmap !== exp_bitmap || out_attr !== exp_attr) begin
      errors++;
      $display("FAIL addr_data: got %h %h, expected %h %h", out_bitmap, out_attr, exp_bitmap, exp_attr);
    end
  endtask

  task automatic test_ulaplus();
    int cyc, uns, ur, ov;
    scr_mem[attr_addr(40, 3)] = 8'hC5;
    pal_mem[6'h35] = 8'hE3;
    pal_mem[6'h38] = 8'h1C;
    build_expected(40, 3, 1'b1);
    do_fetch(8'd40, 5'd3, 1'b1, 0, 0, 1'b0, -1, -1, cyc, uns, ur, ov);
    checks++;
    if (cyc > (ULA_BUILD ? 14 : 8) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ulaplus_done: got %0d cycles, %0d missing", cyc, exp_q.size());
    end
    do_load();
    checks++;
    if (out_attr !== 8'hC5 || out_ink !== exp_ink || out_paper !== exp_paper) begin
      errors++;
      $display("FAIL ulaplus_data: got attr=%h ink=%h paper=%h, expected C5 %h %h",
               out_attr, out_ink, out_paper, exp_ink, exp_paper);
    end
  endtask

  task automatic test_ack_stall();
    int cyc, uns, ur, ov, y, x;
    y = int'($urandom_range(0, 191)); x = int'($urandom_range(0, 31));
    build_expected(y, x, 1'b1);
    do_fetch(8'(y), 5'(x), 1'b1, 0, 5, 1'b1, -1, -1, cyc, uns, ur, ov);
    checks++;
    if (uns != 0 || exp_q.size() != 0 || cyc > 32) begin
      errors++;
      $display("FAIL stall_req: got %0d unstable, %0d missing, %0d cycles, expected 0 0 <=32", uns, exp_q.size(), cyc);
    end
    do_load();
    checks++;
    if ({out_bitmap, out_attr, out_ink, out_paper} !== {exp_bitmap, exp_attr, exp_ink, exp_paper}) begin
      errors++;
      $display("FAIL stall_data: got %h%h%h%h, expected %h%h%h%h", out_bitmap, out_attr, out_ink, out_paper,
               exp_bitmap, exp_attr, exp_ink, exp_paper);
    end
  endtask

  task automatic test_underrun_overrun();
    int cyc, uns, ur, ov;
    logic [7:0] prev_bmp, prev_attr;
    prev_bmp = out_bitmap; prev_attr = out_attr;
    scr_mem[bmp_addr(77, 9)] = 8'h5A;
    build_expected(77, 9, 1'b0);
    do_fetch(8'd77, 5'd9, 1'b0, 0, 3, 1'b0, 3, 1, cyc, uns, ur, ov);
    checks++;
    if (ur != 1 || ov != 1) begin
      errors++;
      $display("FAIL pulses: got underrun=%0d overrun=%0d pulses, expected 1 1", ur, ov);
    end
    checks++;
    if (exp_q.size() != 0 || uns != 0) begin
      errors++;
      $display("FAIL overrun_addr: got %0d missing %0d unstable, expected 0 0", exp_q.size(), uns);
    end
    checks++;
    if (out_bitmap !== prev_bmp || out_attr !== prev_attr || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL underrun_hold: got %h %h v=%b, expected %h %h v=0", out_bitmap, out_attr, out_valid, prev_bmp, prev_attr);
    end
    // Staging still full: a new go must be rejected while idle.
    fetch_go = 1'b1;
    @(negedge clk28);
    fetch_go = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_full: got overrun=%b busy=%b, expected 1 0", overrun, busy);
    end
    do_load();
    checks++;
    if (out_bitmap !== 8'h5A || out_attr !== exp_attr || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_load: got %h %h v=%b, expected 5A %h v=1", out_bitmap, out_attr, out_valid, exp_attr);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, uns, ur, ov;
    exp_q.delete();
    fetch_y = 8'd50; fetch_x = 5'd6; ulaplus_active = 1'b1; fetch_go = 1'b1;
    @(negedge clk28);
    fetch_go = 1'b0; video_read_req_ack = 1'b1;
    @(negedge clk28);
    video_read_req_ack = 1'b0; video_data_valid = 1'b1; vd = 8'h77;
    checks++;
    if (video_read_req !== 1'b1 || video_read_addr !== attr_addr(50, 6)) begin
      errors++;
      $display("FAIL pre_reset: got req=%b addr=%h, expected 1 %h", video_read_req, video_read_addr, attr_addr(50, 6));
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({video_read_req, video_read_req_is_up, video_read_addr, busy, out_valid, out_bitmap, out_attr, out_ink, out_paper} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b addr=%h busy=%b v=%b bmp=%h attr=%h, expected all 0",
               video_read_req, video_read_addr, busy, out_valid, out_bitmap, out_attr);
    end
    video_data_valid = 1'b0;
    @(negedge clk28);
    rst_n = 1'b1;
    @(negedge clk28);
    build_expected(50, 6, 1'b0);
    do_fetch(8'd50, 5'd6, 1'b0, 2, -1, 1'b0, -1, -1, cyc, uns, ur, ov);
    do_load();
    checks++;
    if (exp_q.size() != 0 || out_bitmap !== exp_bitmap || out_attr !== exp_attr || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got %h %h v=%b missing=%0d, expected %h %h v=1 missing=0",
               out_bitmap, out_attr, out_valid, exp_q.size(), exp_bitmap, exp_attr);
    end
  endtask

  task automatic test_random();
    int cyc, uns, ur, ov, y, x;
    bit up;
    for (int i = 0; i < 16; i++) begin
      y = int'($urandom_range(0, 191)); x = int'($urandom_range(0, 31));
      up = 1'($urandom_range(0, 1));
      build_expected(y, x, up);
      do_fetch(8'(y), 5'(x), up, 3, -1, 1'($urandom_range(0, 1)), -1, -1, cyc, uns, ur, ov);
      checks++;
      if (cyc > 32 || uns != 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL rand_fetch %0d: got %0d cycles %0d unstable %0d missing, expected <=32 0 0", i, cyc, uns, exp_q.size());
      end
      do_load();
      checks++;
      if ({out_valid, out_bitmap, out_attr, out_ink, out_paper} !== {1'b1, exp_bitmap, exp_attr, exp_ink, exp_paper}) begin
        errors++;
        $display("FAIL rand_data %0d: got v=%b %h%h%h%h, expected v=1 %h%h%h%h", i, out_valid,
                 out_bitmap, out_attr, out_ink, out_paper, exp_bitmap, exp_attr, exp_ink, exp_paper);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) scr_mem[a] = 8'($urandom);
    for (int a = 0; a < 64; a++) pal_mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_addr();
    test_ulaplus();
    test_ack_stall();
    test_underrun_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
